// File: rtl/fp_convert_arbiter_if.sv
// Purpose: request/result bundle between the requesters, the shared converter and its consumer.
// Latency: none; this is wiring only.
// Backpressure: req_ready grants one requester; res_ready stalls the held result.
interface fp_convert_arbiter_if #(
    parameter int NREQ = 4,
    parameter int XLEN = 32,
    parameter int IDW  = 2
) ();
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*XLEN-1:0] req_data;
    logic [NREQ-1:0]      req_ready;
    logic                 res_valid;
    logic [31:0]          res_data;
    logic [IDW-1:0]       res_id;
    logic                 res_ready;
    logic                 busy;

    // Requesters plus consumer side.
    modport master (
        output req_valid, req_data, res_ready,
        input  req_ready, res_valid, res_data, res_id, busy
    );

    // Arbiter side.
    modport slave (
        input  req_valid, req_data, res_ready,
        output req_ready, res_valid, res_data, res_id, busy
    );
endinterface

// File: rtl/fp_convert_arbiter.sv
// Purpose: round-robin share of one float32->int32 truncating converter among NREQ requesters.
// Latency: operand accepted at edge N gives res_valid after edge N+1; one result per 2 cycles max.
// Backpressure: result held in DONE while res_ready=0, no grants then. FPCVT_ARB_STATS_EN adds counters.

// Combinational float32 -> signed int32, truncation toward zero, saturating on overflow.
module FPU_convert (
    input  logic [31:0] A,
    output logic [31:0] result
);
    logic        sign;
    logic [7:0]  expo;
    logic [31:0] mant;
    logic [31:0] mag;

    // Shift the 24-bit significand into integer position, then apply the sign.
    always_comb begin
        sign   = A[31];
        expo   = A[30:23];
        mant   = {8'd0, 1'b1, A[22:0]};
        mag    = '0;
        result = '0;
        if (expo < 8'd127) begin
            result = '0;
        end else if (expo > 8'd157) begin
            result = sign ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end else begin
            if (expo >= 8'd150) begin
                mag = mant << (expo - 8'd150);
            end else begin
                mag = mant >> (8'd150 - expo);
            end
            result = sign ? (~mag + 32'd1) : mag;
        end
    end
endmodule

module fp_convert_arbiter #(
    parameter int NREQ = 4,
    parameter int XLEN = 32,
    parameter int IDW  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    fp_convert_arbiter_if.slave    bus
`ifdef FPCVT_ARB_STATS_EN
    ,
    output logic [NREQ*16-1:0]     stat_grants,
    output logic [15:0]            stat_stall
`endif
);
    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] op_q, op_d;
    logic [IDW-1:0]  id_q, id_d;
    logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
    logic            res_valid_q, res_valid_d;
    logic [31:0]     res_data_q, res_data_d;
    logic [IDW-1:0]  res_id_q, res_id_d;
    logic            busy_q, busy_d;

    logic            grant_found;
    logic [IDW-1:0]  grant_idx;
    logic            grant_en;
    logic [NREQ-1:0] ready_vec;
    logic [XLEN-1:0] grant_data;
    logic [31:0]     cvt_result;

    FPU_convert u_cvt (
        .A      (op_q),
        .result (cvt_result)
    );

    // Round-robin search: first valid requester at or after rr_ptr, wrapping.
    always_comb begin
        logic [IDW-1:0] cand;
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = IDW'((int'(rr_ptr_q) + i) % NREQ);
            if (!grant_found && bus.req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // A grant is only possible when the datapath is free; reset suppresses it.
    always_comb begin
        grant_en   = !rst && grant_found &&
                     ((state_q == IDLE) || ((state_q == DONE) && bus.res_ready));
        ready_vec  = '0;
        grant_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_idx == IDW'(i)) begin
                ready_vec[i] = grant_en;
                grant_data   = bus.req_data[i*XLEN +: XLEN];
            end
        end
    end

    // Next-state and datapath capture for the IDLE -> CONV -> DONE loop.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        id_d        = id_q;
        rr_ptr_d    = rr_ptr_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_id_d    = res_id_q;
        case (state_q)
            IDLE: begin
                if (grant_en) begin
                    op_d    = grant_data;
                    id_d    = grant_idx;
                    state_d = CONV;
                end
            end
            CONV: begin
                res_data_d  = cvt_result;
                res_id_d    = id_q;
                res_valid_d = 1'b1;
                rr_ptr_d    = (int'(id_q) == NREQ - 1) ? '0 : id_q + 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                if (bus.res_ready) begin
                    res_valid_d = 1'b0;
                    if (grant_en) begin
                        op_d    = grant_data;
                        id_d    = grant_idx;
                        state_d = CONV;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // Single state register; reset wins over any handshake in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            op_q        <= '0;
            id_q        <= '0;
            rr_ptr_q    <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_id_q    <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            id_q        <= id_d;
            rr_ptr_q    <= rr_ptr_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_id_q    <= res_id_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.req_ready = ready_vec;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_id    = res_id_q;
    assign bus.busy      = busy_q;

`ifdef FPCVT_ARB_STATS_EN
    logic [NREQ-1:0][15:0] grant_cnt_q, grant_cnt_d;
    logic [15:0]           stall_q, stall_d;

    // Saturating per-requester grant counts and consumer stall cycles.
    always_comb begin
        grant_cnt_d = grant_cnt_q;
        stall_d     = stall_q;
        for (int i = 0; i < NREQ; i++) begin
            if (ready_vec[i] && grant_cnt_q[i] != 16'hFFFF) begin
                grant_cnt_d[i] = grant_cnt_q[i] + 16'd1;
            end
        end
        if (state_q == DONE && !bus.res_ready && stall_q != 16'hFFFF) begin
            stall_d = stall_q + 16'd1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_cnt_q <= '0;
            stall_q     <= '0;
        end else begin
            grant_cnt_q <= grant_cnt_d;
            stall_q     <= stall_d;
        end
    end

    assign stat_grants = grant_cnt_q;
    assign stat_stall  = stall_q;
`endif
endmodule
